sd_write_model: RTL

//  DDR-to-SD write-back engine; the write-direction counterpart of the model loader's SD read path.
//  On start, streams sd_sec_num x 256 16-bit words from the DDR read port into a prefetch FIFO.

---
 rtl/sd_pkg.sv | 25 ++
 rtl/sd_wr_fifo.sv | 57 +++++
 rtl/sd_write_model.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared constants, widths and FSM encoding for the SD write-back engine.
package sd_pkg;

  localparam int unsigned SD_SECTOR_WORDS = 256;
  localparam int unsigned SD_SEC_NUM_W    = 17;
  localparam int unsigned SD_ADDR_W       = 32;
  localparam int unsigned SD_TOTAL_W      = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_CMD,
    ST_WAIT,
    ST_FIN
  } sd_wr_state_e;

  // Total 16-bit words for a transfer of n sectors.
  function automatic logic [SD_TOTAL_W-1:0] total_words(
    input logic [SD_SEC_NUM_W-1:0] n,
    input int unsigned             sector_words
  );
    return SD_TOTAL_W'(n) * SD_TOTAL_W'(sector_words);
  endfunction

endpackage

// File: rtl/sd_wr_fifo.sv
// Synchronous prefetch FIFO with occupancy output and flush.
module sd_wr_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             full, do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a word when one leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Storage array; no reset needed, contents are qualified by level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sd_write_model.sv
// DDR-to-SD write-back engine: prefetches DDR words and feeds SD sector writes.
module sd_write_model #(
  parameter int unsigned FIFO_DEPTH   = 32,
  parameter int unsigned SECTOR_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] sd_start_sec,
  input  logic [16:0] sd_sec_num,
  output logic        ddr_rd_en,
  input  logic        ddr_rd_valid,
  input  logic [15:0] ddr_rd_data,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_sec_start,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        underrun
);
  import sd_pkg::*;

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW_W  = $clog2(SECTOR_WORDS) + 1;

  sd_wr_state_e            state_q, state_d;
  logic [SD_SEC_NUM_W-1:0] sec_num_q, sec_cnt_q;
  logic [SD_ADDR_W-1:0]    addr_q;
  logic [SD_TOTAL_W-1:0]   req_cnt_q, ret_cnt_q, outstanding, total;
  logic [SW_W-1:0]         sec_pop_q;
  logic                    underrun_q;
  logic [15:0]             wr_data_q;
  logic                    wb_d0_q, wb_d1_q;

  logic                    accept, busy_w, fifo_push, fifo_empty, do_pop;
  logic                    sec_complete, last_sec, fill_ok, room;
  logic [LVL_W-1:0]        fifo_level;
  logic [15:0]             fifo_rdata;
  logic [31:0]             words_left, fill_target;

  assign accept       = start && (state_q == ST_IDLE) && (sd_sec_num != '0);
  assign busy_w       = (state_q == ST_PREFILL) || (state_q == ST_CMD) || (state_q == ST_WAIT);
  assign total        = total_words(sec_num_q, SECTOR_WORDS);
  assign outstanding  = req_cnt_q - ret_cnt_q;
  assign room         = (SD_TOTAL_W'(fifo_level) + outstanding) < SD_TOTAL_W'(FIFO_DEPTH);
  assign ddr_rd_en    = busy_w && (req_cnt_q < total) && room;
  // Returns arriving while idle belong to an aborted transfer and are dropped.
  assign fifo_push    = busy_w && ddr_rd_valid;
  assign do_pop       = wr_req && !fifo_empty;
  assign sec_complete = wb_d1_q && !wb_d0_q;
  assign last_sec     = (sec_cnt_q == sec_num_q - SD_SEC_NUM_W'(1));

  assign words_left   = 32'(SECTOR_WORDS) - 32'(sec_pop_q);
  assign fill_target  = (words_left < 32'(FIFO_DEPTH)) ? words_left : 32'(FIFO_DEPTH);
  assign fill_ok      = 32'(fifo_level) >= fill_target;

  assign wr_sec_start = (state_q == ST_CMD);
  assign done         = (state_q == ST_FIN);
  assign busy         = busy_w;
  assign wr_sec_addr  = addr_q;
  assign wr_data      = wr_data_q;
  assign underrun     = underrun_q;

  sd_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .push  (fifo_push),
    .wdata (ddr_rd_data),
    .pop   (wr_req),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .empty (fifo_empty)
  );

  // Next-state logic for the sector sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_PREFILL;
      ST_PREFILL: if (fill_ok) state_d = ST_CMD;
      ST_CMD:     state_d = ST_WAIT;
      ST_WAIT:    if (sec_complete) state_d = last_sec ? ST_FIN : ST_PREFILL;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register and wr_busy edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wb_d0_q <= 1'b0;
      wb_d1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_d0_q <= wr_busy;
      wb_d1_q <= wb_d0_q;
    end
  end

  // Transfer bookkeeping: sector address/count and DDR request/return counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_num_q <= '0;
      sec_cnt_q <= '0;
      addr_q    <= '0;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
      sec_pop_q <= '0;
    end else if (accept) begin
      sec_num_q <= sd_sec_num;
      sec_cnt_q <= '0;
      addr_q    <= sd_start_sec;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
      sec_pop_q <= '0;
    end else begin
      if (ddr_rd_en) req_cnt_q <= req_cnt_q + SD_TOTAL_W'(1);
      if (fifo_push) ret_cnt_q <= ret_cnt_q + SD_TOTAL_W'(1);
      if ((state_q == ST_WAIT) && sec_complete) begin
        sec_cnt_q <= sec_cnt_q + SD_SEC_NUM_W'(1);
        addr_q    <= addr_q + SD_ADDR_W'(1);
        sec_pop_q <= '0;
      end else if (busy_w && do_pop && (sec_pop_q < SW_W'(SECTOR_WORDS))) begin
        sec_pop_q <= sec_pop_q + SW_W'(1);
      end
    end
  end

  // SD data register and sticky underrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (wr_req) wr_data_q <= fifo_empty ? 16'h0000 : fifo_rdata;
      if (accept)                     underrun_q <= 1'b0;
      else if (wr_req && fifo_empty)  underrun_q <= 1'b1;
    end
  end

endmodule
